// File: rtl/reg_serializer.sv
// reg_serializer: valid/ready parallel-to-serial converter with last-beat flag
module reg_serializer #(
  parameter int W = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_bit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0]   state;
  logic [W-1:0] sreg;
  logic [CW-1:0] cnt;
  logic          in_fire;
  logic          out_fire;
  always_comb begin
    out_valid = state == SHIFT;
    busy      = out_valid;
    out_bit   = MSB_FIRST ? sreg[W-1] : sreg[0];
    out_last  = out_valid && (cnt == CW'(W - 1));
    out_fire  = out_valid && out_ready;
    in_ready  = !rst && (state == IDLE || (out_fire && out_last));
    in_fire   = in_valid && in_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else if (in_fire) begin
      state <= SHIFT;
      sreg  <= in_data;
      cnt   <= '0;
    end else if (out_fire && out_last) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else if (out_fire) begin
      sreg  <= MSB_FIRST ? sreg << 1 : sreg >> 1;
      cnt   <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_reg_serializer.sv
// tb_reg_serializer: queue-model check of LSB-first and MSB-first serializers
module tb_reg_serializer;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic [7:0] in_data;
  logic ir_l, ob_l, ov_l, ol_l, bz_l;
  logic ir_m, ob_m, ov_m, ol_m, bz_m;
  int checks = 0;
  int passed = 0;
  logic acc;
  logic ql[$];
  logic qm[$];
  logic [7:0] pend[$];

  always #5 clk = ~clk;

  reg_serializer #(.W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir_l),
    .out_bit(ob_l), .out_valid(ov_l), .out_ready(out_ready), .out_last(ol_l), .busy(bz_l)
  );

  reg_serializer #(.W(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir_m),
    .out_bit(ob_m), .out_valid(ov_m), .out_ready(out_ready), .out_last(ol_m), .busy(bz_m)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
  endtask

  task automatic cyc(input logic r, input logic iv, input logic [7:0] d, input logic ordy);
    int n;
    logic eir, ebl, ebm;
    rst = r;
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    #1;
    n = ql.size();
    eir = !r && (n == 0 || (ordy && n == 1));
    ebl = (n > 0) ? ql[0] : 1'b0;
    ebm = (n > 0) ? qm[0] : 1'b0;
    chk("in_ready_lsb", ir_l, eir);
    chk("in_ready_msb", ir_m, eir);
    chk("out_valid_lsb", ov_l, n > 0);
    chk("out_valid_msb", ov_m, n > 0);
    chk("busy_lsb", bz_l, n > 0);
    chk("busy_msb", bz_m, n > 0);
    chk("out_bit_lsb", ob_l, ebl);
    chk("out_bit_msb", ob_m, ebm);
    chk("out_last_lsb", ol_l, n == 1);
    chk("out_last_msb", ol_m, n == 1);
    acc = 1'b0;
    if (r) begin
      ql.delete();
      qm.delete();
    end else begin
      if (n > 0 && ordy) begin
        void'(ql.pop_front());
        void'(qm.pop_front());
      end
      if (iv && eir) begin
        for (int i = 0; i < 8; i++) begin
          ql.push_back(d[i]);
          qm.push_back(d[7-i]);
        end
        acc = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int ncyc, input int mode);
    logic ordy;
    for (int c = 0; c < ncyc; c++) begin
      ordy = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 3 == 0) : 1'($urandom_range(0, 1));
      if (pend.size() > 0) cyc(1'b0, 1'b1, pend[0], ordy);
      else cyc(1'b0, 1'b0, 8'h00, ordy);
      if (acc) void'(pend.pop_front());
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc(1'b1, 1'b1, 8'hA5, 1'b1);
    cyc(1'b1, 1'b1, 8'hA5, 1'b1);
    drain(2, 0);
    pend.push_back(8'hA5);
    drain(11, 0);
    pend.push_back(8'h81);
    drain(11, 0);
    pend.push_back(8'h3C);
    drain(30, 1);
    pend.push_back(8'hFF);
    pend.push_back(8'h00);
    drain(20, 0);
    pend.push_back(8'hF0);
    drain(4, 0);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    drain(2, 0);
    pend.push_back(8'h01);
    drain(11, 0);
    for (int k = 0; k < 40; k++) pend.push_back(8'($urandom));
    drain(400, 2);
    for (int c = 0; c < 400; c++)
      cyc(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
